// File: rtl/perceptron_param_if.sv
// Handshake and observation bundle for the perceptron block.
// The master drives samples and result acceptance; the slave is the perceptron.
interface perceptron_param_if #(
    parameter int N_IN     = 2,
    parameter int W_BITS   = 4,
    parameter int CNT_BITS = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic [N_IN-1:0]              x;
    logic                         s;
    logic                         train;
    logic                         out_valid;
    logic                         out_ready;
    logic                         z;
    logic [1:0]                   delta;
    logic [(N_IN+1)*W_BITS-1:0]   w_flat;
    logic [CNT_BITS-1:0]          err_cnt;

    modport master (
        output in_valid, x, s, train, out_ready,
        input  in_ready, out_valid, z, delta, w_flat, err_cnt
    );

    modport slave (
        input  in_valid, x, s, train, out_ready,
        output in_ready, out_valid, z, delta, w_flat, err_cnt
    );
endinterface

// File: rtl/perceptron_param.sv
// Sequential single-neuron perceptron: serial multiply-accumulate, step output,
// and saturating perceptron-rule weight update, one weight per cycle.
module perceptron_param #(
    parameter int                         N_IN     = 2,
    parameter int                         W_BITS   = 4,
    parameter logic [(N_IN+1)*W_BITS-1:0] W_INIT   = 12'h021,
    parameter int                         CNT_BITS = 8
) (
    input logic                clk,
    input logic                rst,
    perceptron_param_if.slave  bus
);

    localparam int IDX_BITS = $clog2(N_IN + 1);
    localparam int ACC_W    = W_BITS + $clog2(N_IN + 1) + 1;

    typedef enum logic [2:0] {IDLE, MAC, EVAL, UPDATE, RESP} state_t;

    state_t                 state;
    logic [IDX_BITS-1:0]    idx;
    logic [N_IN-1:0]        x_lat;
    logic                   s_lat;
    logic                   train_lat;
    logic [ACC_W-1:0]       acc;
    logic [W_BITS-1:0]      w [0:N_IN];
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic                   z_r;
    logic [1:0]             delta_r;
    logic [CNT_BITS-1:0]    err_cnt_r;

    // Slot N_IN is the bias; its input is tied to 1 so MAC and UPDATE treat it uniformly.
    logic [N_IN:0]          x_ext;
    logic                   sel_x;
    logic [W_BITS-1:0]      sel_w;
    logic [ACC_W-1:0]       acc_add;
    logic                   last_mac;
    logic                   last_upd;
    logic                   z_new;
    logic                   mismatch;
    logic [1:0]             delta_new;

    function automatic logic [W_BITS-1:0] sat_add(input logic [W_BITS-1:0] a,
                                                  input logic [1:0]        d);
        logic [W_BITS:0] sum;
        sum = {a[W_BITS-1], a} + {{(W_BITS-1){d[1]}}, d};
        if (sum[W_BITS] != sum[W_BITS-1])
            sat_add = sum[W_BITS] ? {1'b1, {(W_BITS-1){1'b0}}}
                                  : {1'b0, {(W_BITS-1){1'b1}}};
        else
            sat_add = sum[W_BITS-1:0];
    endfunction

    assign x_ext = {1'b1, x_lat};

    always_comb begin
        sel_x = 1'b0;
        sel_w = '0;
        for (int k = 0; k <= N_IN; k++) begin
            if (idx == IDX_BITS'(k)) begin
                sel_x = x_ext[k];
                sel_w = w[k];
            end
        end
    end

    assign acc_add   = sel_x ? {{(ACC_W-W_BITS){sel_w[W_BITS-1]}}, sel_w} : '0;
    assign last_mac  = (idx == IDX_BITS'(N_IN - 1));
    assign last_upd  = (idx == IDX_BITS'(N_IN));
    assign z_new     = !acc[ACC_W-1] && (acc != '0);
    assign mismatch  = (s_lat != z_new);
    assign delta_new = mismatch ? (s_lat ? 2'b01 : 2'b11) : 2'b00;

    // Control, datapath and every output are registered in this one block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            x_lat       <= '0;
            s_lat       <= 1'b0;
            train_lat   <= 1'b0;
            acc         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            z_r         <= 1'b0;
            delta_r     <= 2'b00;
            err_cnt_r   <= '0;
            for (int k = 0; k <= N_IN; k++)
                w[k] <= W_INIT[k*W_BITS +: W_BITS];
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_lat      <= bus.x;
                        s_lat      <= bus.s;
                        train_lat  <= bus.train;
                        acc        <= {{(ACC_W-W_BITS){w[N_IN][W_BITS-1]}}, w[N_IN]};
                        idx        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + acc_add;
                    if (last_mac) begin
                        idx   <= '0;
                        state <= EVAL;
                    end else begin
                        idx <= idx + IDX_BITS'(1);
                    end
                end
                EVAL: begin
                    z_r     <= z_new;
                    delta_r <= delta_new;
                    if (mismatch && (err_cnt_r != '1))
                        err_cnt_r <= err_cnt_r + CNT_BITS'(1);
                    if (train_lat && mismatch) begin
                        state <= UPDATE;
                    end else begin
                        out_valid_r <= 1'b1;
                        state       <= RESP;
                    end
                end
                UPDATE: begin
                    for (int k = 0; k <= N_IN; k++) begin
                        if ((idx == IDX_BITS'(k)) && x_ext[k])
                            w[k] <= sat_add(w[k], delta_r);
                    end
                    if (last_upd) begin
                        idx         <= '0;
                        out_valid_r <= 1'b1;
                        state       <= RESP;
                    end else begin
                        idx <= idx + IDX_BITS'(1);
                    end
                end
                RESP: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.z         = z_r;
    assign bus.delta     = delta_r;
    assign bus.err_cnt   = err_cnt_r;

    for (genvar g = 0; g <= N_IN; g++) begin : g_flat
        assign bus.w_flat[g*W_BITS +: W_BITS] = w[g];
    end

endmodule

// File: tb/tb_perceptron_param.sv
// Directed bench for perceptron_param: table of training/inference vectors
// plus hand sequences for backpressure, saturation and mid-update reset.
module tb_perceptron_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    always #5 clk = ~clk;

    perceptron_param_if #(.N_IN(2), .W_BITS(4), .CNT_BITS(8)) bus ();
    perceptron_param_if #(.N_IN(2), .W_BITS(4), .CNT_BITS(8)) bus2 ();

    perceptron_param #(.N_IN(2), .W_BITS(4), .W_INIT(12'h021), .CNT_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    perceptron_param #(.N_IN(2), .W_BITS(4), .W_INIT(12'h807), .CNT_BITS(8)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    typedef struct {
        logic [1:0]  x;
        logic        s;
        logic        train;
        logic        z;
        logic [1:0]  delta;
        logic [11:0] w_flat;
        int          lat;
        int          err;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Latency is counted in rising edges, the accepting edge being edge 1.
    task automatic applyStimulus(input logic [1:0] xv, input logic sv, input logic tv,
                                 output int lat_o);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.x         = xv;
        bus.s         = sv;
        bus.train     = tv;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat_o = 1;
        while (!bus.out_valid && lat_o < 40) begin
            @(posedge clk);
            #1;
            lat_o++;
        end
    endtask

    task automatic releaseResp();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{x: 2'b11, s: 1'b1, train: 1'b1, z: 1'b1, delta: 2'b00, w_flat: 12'h021, lat: 4, err: 0};
        vecs[1] = '{x: 2'b01, s: 1'b0, train: 1'b1, z: 1'b1, delta: 2'b11, w_flat: 12'hF20, lat: 7, err: 1};
        vecs[2] = '{x: 2'b00, s: 1'b0, train: 1'b0, z: 1'b0, delta: 2'b00, w_flat: 12'hF20, lat: 4, err: 1};
        vecs[3] = '{x: 2'b00, s: 1'b1, train: 1'b1, z: 1'b0, delta: 2'b01, w_flat: 12'h020, lat: 7, err: 2};
        vecs[4] = '{x: 2'b10, s: 1'b0, train: 1'b1, z: 1'b1, delta: 2'b11, w_flat: 12'hF10, lat: 7, err: 3};
        vecs[5] = '{x: 2'b11, s: 1'b1, train: 1'b0, z: 1'b0, delta: 2'b01, w_flat: 12'hF10, lat: 4, err: 4};
        vecs[6] = '{x: 2'b11, s: 1'b1, train: 1'b1, z: 1'b0, delta: 2'b01, w_flat: 12'h021, lat: 7, err: 5};

        bus.in_valid = 1'b0; bus.x = '0; bus.s = 1'b0; bus.train = 1'b0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.x = '0; bus2.s = 1'b0; bus2.train = 1'b0; bus2.out_ready = 1'b0;

        #12;
        checkOutput("rst_w_flat",    32'(bus.w_flat),    32'h021);
        checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_err_cnt",   32'(bus.err_cnt),   32'd0);
        checkOutput("rst_z",         32'(bus.z),         32'd0);
        checkOutput("rst_delta",     32'(bus.delta),     32'd0);
        checkOutput("rst2_w_flat",   32'(bus2.w_flat),   32'h807);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].x, vecs[i].s, vecs[i].train, lat);
            checkOutput($sformatf("v%0d_lat", i),     32'(lat),           32'(vecs[i].lat));
            checkOutput($sformatf("v%0d_z", i),       32'(bus.z),         32'(vecs[i].z));
            checkOutput($sformatf("v%0d_delta", i),   32'(bus.delta),     32'(vecs[i].delta));
            checkOutput($sformatf("v%0d_w_flat", i),  32'(bus.w_flat),    32'(vecs[i].w_flat));
            checkOutput($sformatf("v%0d_err_cnt", i), 32'(bus.err_cnt),   32'(vecs[i].err));
            releaseResp();
            checkOutput($sformatf("v%0d_idle", i),    32'(bus.in_ready),  32'd1);
        end

        // Positive saturation of w0 and bias moving away from its minimum.
        @(negedge clk);
        bus2.in_valid = 1'b1; bus2.x = 2'b01; bus2.s = 1'b1; bus2.train = 1'b1; bus2.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        lat = 1;
        while (!bus2.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("sat_lat",     32'(lat),            32'd7);
        checkOutput("sat_z",       32'(bus2.z),         32'd0);
        checkOutput("sat_delta",   32'(bus2.delta),     32'd1);
        checkOutput("sat_w_flat",  32'(bus2.w_flat),    32'h907);
        checkOutput("sat_err_cnt", 32'(bus2.err_cnt),   32'd1);
        @(negedge clk);
        bus2.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus2.out_ready = 1'b0;

        applyStimulus(2'b01, 1'b1, 1'b0, lat);
        checkOutput("bp_lat", 32'(lat), 32'd4);
        bus.in_valid = 1'b1;
        bus.x = 2'b10; bus.s = 1'b0; bus.train = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
            checkOutput($sformatf("bp%0d_in_ready", c),  32'(bus.in_ready),  32'd0);
            checkOutput($sformatf("bp%0d_z", c),         32'(bus.z),         32'd1);
            checkOutput($sformatf("bp%0d_delta", c),     32'(bus.delta),     32'd0);
            checkOutput($sformatf("bp%0d_w_flat", c),    32'(bus.w_flat),    32'h021);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checkOutput("bp_rel_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("bp_rel_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("bp_err_cnt",       32'(bus.err_cnt),   32'd5);

        // Reset during the second UPDATE cycle of a w0-decrementing transaction.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.x = 2'b01; bus.s = 1'b0; bus.train = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("mid_upd_w_flat", 32'(bus.w_flat), 32'h020);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_w_flat",    32'(bus.w_flat),    32'h021);
        checkOutput("mid_rst_err_cnt",   32'(bus.err_cnt),   32'd0);
        checkOutput("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(2'b01, 1'b0, 1'b0, lat);
        checkOutput("post_lat",     32'(lat),          32'd4);
        checkOutput("post_z",       32'(bus.z),        32'd1);
        checkOutput("post_delta",   32'(bus.delta),    32'd3);
        checkOutput("post_err_cnt", 32'(bus.err_cnt),  32'd1);
        checkOutput("post_w_flat",  32'(bus.w_flat),   32'h021);
        releaseResp();
        checkOutput("post_idle",    32'(bus.in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
